// File: rtl/dispatch_queue.sv
`default_nettype none
// dispatch_queue: in-order buffer of renamed micro-ops that snoops the CDB for
// missing operands and dispatches its head to one of CH back-pressured channels.
module dispatch_queue #(
  parameter int DEPTH  = 4,
  parameter int CH     = 2,
  parameter int TYPE_W = 5,
  parameter int ROB_W  = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    _clear,
  input  logic                    _enq_valid,
  output logic                    _enq_ready,
  input  logic [$clog2(CH)-1:0]   _enq_chan,
  input  logic [TYPE_W-1:0]       _enq_type,
  input  logic [ROB_W-1:0]        _enq_rob_id,
  input  logic [31:0]             _enq_r1,
  input  logic [31:0]             _enq_r2,
  input  logic                    _enq_has_dep1,
  input  logic                    _enq_has_dep2,
  input  logic [ROB_W-1:0]        _enq_dep1,
  input  logic [ROB_W-1:0]        _enq_dep2,
  input  logic [31:0]             _enq_imm,
  input  logic                    _cdb_valid,
  input  logic [ROB_W-1:0]        _cdb_rob_id,
  input  logic [31:0]             _cdb_value,
  input  logic [CH-1:0]           _chan_full,
  output logic                    _out_valid,
  output logic [$clog2(CH)-1:0]   _out_chan,
  output logic [TYPE_W-1:0]       _out_type,
  output logic [ROB_W-1:0]        _out_rob_id,
  output logic [31:0]             _out_r1,
  output logic [31:0]             _out_r2,
  output logic [31:0]             _out_imm,
  output logic                    _out_has_dep1,
  output logic                    _out_has_dep2,
  output logic [ROB_W-1:0]        _out_dep1,
  output logic [ROB_W-1:0]        _out_dep2,
  output logic                    _out_fire,
  output logic [$clog2(DEPTH):0]  _count
);

  localparam int CHW = $clog2(CH);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  typedef struct packed {
    logic [CHW-1:0]    chan;
    logic [TYPE_W-1:0] utype;
    logic [ROB_W-1:0]  rob_id;
    logic [31:0]       r1;
    logic [31:0]       r2;
    logic [31:0]       imm;
    logic              hd1;
    logic              hd2;
    logic [ROB_W-1:0]  dep1;
    logic [ROB_W-1:0]  dep2;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  entry_t          enq_ent;
  entry_t          head_ent;
  logic            enq_do;

  // Resolve any operand still waiting on the ROB id being broadcast this cycle.
  function automatic entry_t snoop(input entry_t e, input logic v,
                                   input logic [ROB_W-1:0] id, input logic [31:0] val);
    entry_t r;
    r = e;
    if (v && e.hd1 && (e.dep1 == id)) begin
      r.r1  = val;
      r.hd1 = 1'b0;
    end
    if (v && e.hd2 && (e.dep2 == id)) begin
      r.r2  = val;
      r.hd2 = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    enq_ent.chan   = _enq_chan;
    enq_ent.utype  = _enq_type;
    enq_ent.rob_id = _enq_rob_id;
    enq_ent.r1     = _enq_r1;
    enq_ent.r2     = _enq_r2;
    enq_ent.imm    = _enq_imm;
    enq_ent.hd1    = _enq_has_dep1;
    enq_ent.hd2    = _enq_has_dep2;
    enq_ent.dep1   = _enq_dep1;
    enq_ent.dep2   = _enq_dep2;
  end

  assign head_ent   = snoop(mem_q[head_q], _cdb_valid, _cdb_rob_id, _cdb_value);

  assign _enq_ready = !rst_in && rdy_in && !_clear && (count_q < CW'(DEPTH));
  assign enq_do     = _enq_valid && _enq_ready;
  assign _out_valid = rdy_in && !_clear && (count_q != '0);
  assign _out_fire  = _out_valid && !_chan_full[head_ent.chan];
  assign _count     = count_q;

  assign _out_chan     = head_ent.chan;
  assign _out_type     = head_ent.utype;
  assign _out_rob_id   = head_ent.rob_id;
  assign _out_r1       = head_ent.r1;
  assign _out_r2       = head_ent.r2;
  assign _out_imm      = head_ent.imm;
  assign _out_has_dep1 = head_ent.hd1;
  assign _out_has_dep2 = head_ent.hd2;
  assign _out_dep1     = head_ent.dep1;
  assign _out_dep2     = head_ent.dep2;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (_clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_d[i].hd1 = 1'b0;
          mem_d[i].hd2 = 1'b0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_d[i] = snoop(mem_q[i], _cdb_valid, _cdb_rob_id, _cdb_value);
        end
        // The tail slot is free whenever enqueue is allowed, so the write wins.
        if (enq_do) begin
          mem_d[tail_q] = snoop(enq_ent, _cdb_valid, _cdb_rob_id, _cdb_value);
          tail_d        = tail_q + 1'b1;
        end
        if (_out_fire) begin
          head_d = head_q + 1'b1;
        end
        count_d = count_q + CW'(enq_do) - CW'(_out_fire);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised decoded-instruction buffer between the decoder and the issue targets (reservation station, load/store buffer, further channels). It holds up to DEPTH renamed micro-ops in program order and snoops the common data bus (CDB) so operands waiting in the queue are captured. It dispatches the head entry to one of CH target channels under per-channel back-pressure and flushes completely on `_clear`. Decode no longer stalls whenever a single target is momentarily full.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- CH, 2, number of target channels; ≥2 (0 = RS, 1 = LSB by convention)
- TYPE_W, 5, micro-op type width
- ROB_W, 5, ROB id width

- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- rdy_in  in  1  global ready; low freezes all state
- _clear  in  1  flush (misprediction)
- _enq_valid  in  1  decoder presents a micro-op
- _enq_ready  out  1  queue can accept this cycle
- _enq_chan  in  $clog2(CH)  target channel
- _enq_type  in  TYPE_W  micro-op type
- _enq_rob_id  in  ROB_W  allocated ROB entry
- _enq_r1, _enq_r2  in  32  operand values (valid when no dependency)
- _enq_has_dep1, _enq_has_dep2  in  1  operand waits on ROB entry
- _enq_dep1, _enq_dep2  in  ROB_W  producing ROB id
- _enq_imm  in  32  immediate
- _cdb_valid  in  1  broadcast this cycle
- _cdb_rob_id  in  ROB_W  broadcasting ROB id
- _cdb_value  in  32  broadcast result
- _chan_full  in  CH  per-channel full, bit i = channel i
- _out_valid  out  1  head entry presented
- _out_chan, _out_type, _out_rob_id, _out_r1, _out_r2, _out_imm, _out_has_dep1/2, _out_dep1/2  out  (as enq)  head entry fields
- _out_fire  out  1  head dispatched this cycle
- _count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: circular array; head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH; `_count` register 0..DEPTH.
- `_enq_ready = !rst_in & rdy_in & !_clear & (_count < DEPTH)`. Enqueue when `_enq_valid & _enq_ready`. A full queue does not accept in the same cycle it dequeues.
- `_out_valid = rdy_in & !_clear & (_count != 0)`.
- `_out_fire = _out_valid & !_chan_full[_out_chan]`. Head pointer advances on fire.
- Dispatch is strictly in order. A blocked head blocks all younger entries, including entries bound for other channels.
- CDB capture each enabled cycle. For every valid stored entry and each operand k, if `has_depk & _cdb_valid & depk == _cdb_rob_id`, then rk ← `_cdb_value` and has_depk ← 0.
- Enqueue bypass: the same match is applied to the incoming micro-op before it is written.
- Output bypass: the `_out_*` operand fields apply the same match combinationally to the head entry. A dispatched entry therefore never misses a broadcast in its fire cycle.
- Counter update: `_count` += enq − fire, so simultaneous enqueue and fire leaves it unchanged.
- `_clear` (synchronous, takes priority over enqueue, fire and capture): head, tail and `_count` ← 0, all entries invalid. The enqueue offered that cycle is dropped.
- `rdy_in` low: no pointer, count or entry change. `_out_valid`, `_out_fire` and `_enq_ready` read 0.
- Reset (asynchronous): head = tail = 0, `_count` = 0, all has_dep bits 0. While `rst_in` is high, `_enq_ready`, `_out_valid` and `_out_fire` are 0. Data outputs are don't-care while `_out_valid` is 0.

## Timing
- Enqueue-to-present latency: 1 cycle. An entry written at edge t is visible on `_out_*` after t when the queue was empty.
- Throughput: 1 enqueue and 1 dispatch per cycle.
- CDB capture latency: 0 cycles at the outputs (bypass). Stored at the next edge.
- `_chan_full` is sampled combinationally. Targets must treat `_out_fire` as the write strobe.
- Boundaries:
  - full + fire: `_count` goes DEPTH → DEPTH−1, and `_enq_ready` rises the next cycle.
  - pointer wrap at DEPTH−1 → 0 has no bubble.
  - `_clear` with `_rob`-side reset in the same cycle: queue is empty next cycle.

## Test plan
- Reset, then enqueue 4 ops (DEPTH=4) to channel 0 with `_chan_full=2'b01` -> `_count=4`, `_enq_ready=0`, `_out_fire=0`. Release full -> 4 fires on consecutive cycles in ROB-id order 3,4,5,6.
- Head on chan 1 with `_chan_full=2'b10`, next entry on chan 0 -> no fire for either until bit 1 clears (in-order blocking).
- Stored entry with has_dep1=1, dep1=7. Drive `_cdb_valid=1`, `_cdb_rob_id=7`, `_cdb_value=32'hDEAD_BEEF` -> `_out_r1=32'hDEAD_BEEF`, `_out_has_dep1=0` in the same cycle, and the values persist afterwards.
- Enqueue with dep2=9 in the same cycle as a CDB broadcast for id 9, value 5 -> the entry is stored with has_dep2=0, r2=5.
- Fill 3 entries, assert `_clear` together with `_enq_valid` -> `_count=0` next cycle, `_out_valid=0`, and the dropped op never appears.
- Run 20 enqueue/fire cycles with random `_chan_full` across wrap, then assert `rst_in` mid-stream asynchronously -> outputs go low immediately, `_count=0`, and the order observed before reset matches the enqueue order.
